// File: rtl/exec_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exec_forward_unit
//  Description : Execute-stage operand forwarding and load-use hazard unit.
//                Resolves NUM_SRC source operands against LANES result lanes
//                in EX, MEM, WB and a HOLD_DEPTH-deep stall-capture buffer.
//                Raises stall on load-use hazards.
//  Revision    : 1.0  initial release
// ============================================================================
module exec_forward_unit #(
    parameter int XLEN           = 32,
    parameter int REG_BITS       = 5,
    parameter int LANES          = 2,
    parameter int NUM_SRC        = 2,
    parameter int HOLD_DEPTH     = 2,
    parameter bit LOAD_STALL_MEM = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         halt,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_BITS-1:0]  src_reg,
    input  logic [NUM_SRC*XLEN-1:0]      rf_data,
    input  logic                         ex_valid,
    input  logic                         ex_is_load,
    input  logic [LANES*REG_BITS-1:0]    ex_tgt,
    input  logic [LANES*XLEN-1:0]        ex_result,
    input  logic                         mem_valid,
    input  logic                         mem_is_load,
    input  logic [LANES*REG_BITS-1:0]    mem_tgt,
    input  logic [LANES*XLEN-1:0]        mem_result,
    input  logic                         wb_valid,
    input  logic [LANES*REG_BITS-1:0]    wb_tgt,
    input  logic [LANES*XLEN-1:0]        wb_result,
    output logic [NUM_SRC*XLEN-1:0]      operand,
    output logic                         stall,
    output logic                         hold_ovf,
    output logic [CNT_W-1:0]             stall_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stall-capture buffer: entry 0 is the newest WB snapshot
    logic [HOLD_DEPTH-1:0]        r_hold_valid;
    logic [LANES*REG_BITS-1:0]    r_hold_tgt  [HOLD_DEPTH];
    logic [LANES*XLEN-1:0]        r_hold_data [HOLD_DEPTH];
    logic                         r_hold_ovf;
    logic [CNT_W-1:0]             r_stall_count;
    logic                         w_stall;
    logic                         w_advance;

    // A lane hits a source when its stage is live, it writes a real register
    // (index 0 is hard-wired zero) and the indices agree.
    function automatic logic lane_hit(input logic                v,
                                      input logic [REG_BITS-1:0] t,
                                      input logic [REG_BITS-1:0] s);
        return v && (t != '0) && (t == s);
    endfunction

    // Load-use hazard detection against EX (and optionally MEM) loads
    always_comb begin
        logic ex_dep;
        logic mem_dep;
        ex_dep  = 1'b0;
        mem_dep = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_hit(ex_valid, ex_tgt[l*REG_BITS +: REG_BITS],
                             src_reg[k*REG_BITS +: REG_BITS]))
                    ex_dep = 1'b1;
                if (lane_hit(mem_valid, mem_tgt[l*REG_BITS +: REG_BITS],
                             src_reg[k*REG_BITS +: REG_BITS]))
                    mem_dep = 1'b1;
            end
        end
        w_stall = id_valid && ((ex_is_load && ex_dep) ||
                               (LOAD_STALL_MEM && mem_is_load && mem_dep));
    end

    // Operand select: sources are scanned lowest priority first so the
    // highest-priority hit (EX lane 0) is the last one to assign.
    always_comb begin
        operand = rf_data;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int h = HOLD_DEPTH-1; h >= 0; h--) begin
                for (int l = LANES-1; l >= 0; l--) begin
                    if (lane_hit(r_hold_valid[h], r_hold_tgt[h][l*REG_BITS +: REG_BITS],
                                 src_reg[k*REG_BITS +: REG_BITS]))
                        operand[k*XLEN +: XLEN] = r_hold_data[h][l*XLEN +: XLEN];
                end
            end
            for (int l = LANES-1; l >= 0; l--) begin
                if (lane_hit(wb_valid, wb_tgt[l*REG_BITS +: REG_BITS],
                             src_reg[k*REG_BITS +: REG_BITS]))
                    operand[k*XLEN +: XLEN] = wb_result[l*XLEN +: XLEN];
            end
            for (int l = LANES-1; l >= 0; l--) begin
                if (lane_hit(mem_valid, mem_tgt[l*REG_BITS +: REG_BITS],
                             src_reg[k*REG_BITS +: REG_BITS]))
                    operand[k*XLEN +: XLEN] = mem_result[l*XLEN +: XLEN];
            end
            for (int l = LANES-1; l >= 0; l--) begin
                if (lane_hit(ex_valid, ex_tgt[l*REG_BITS +: REG_BITS],
                             src_reg[k*REG_BITS +: REG_BITS]))
                    operand[k*XLEN +: XLEN] = ex_result[l*XLEN +: XLEN];
            end
        end
    end

    assign w_advance = w_stall && !halt;

    // Hold valids and stall statistics: shift in WB while stalled, flush otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid  <= '0;
            r_hold_ovf    <= 1'b0;
            r_stall_count <= '0;
        end else if (!halt) begin
            if (w_stall) begin
                r_hold_valid[0] <= wb_valid;
                for (int i = 1; i < HOLD_DEPTH; i++)
                    r_hold_valid[i] <= r_hold_valid[i-1];
                if (r_hold_valid[HOLD_DEPTH-1])
                    r_hold_ovf <= 1'b1;
                if (r_stall_count != '1)
                    r_stall_count <= r_stall_count + c_cnt_one;
            end else begin
                r_hold_valid <= '0;
            end
        end
    end

    // Hold payload shifts with the valids; left stale when invalidated
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_hold_tgt[0]  <= wb_tgt;
            r_hold_data[0] <= wb_result;
            for (int i = 1; i < HOLD_DEPTH; i++) begin
                r_hold_tgt[i]  <= r_hold_tgt[i-1];
                r_hold_data[i] <= r_hold_data[i-1];
            end
        end
    end

    assign stall       = w_stall;
    assign hold_ovf    = r_hold_ovf;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
